// File: rtl/multicycle_controller.sv
// Main-control FSM for the multicycle MIPS core. One shared ALU, memory port
// and register file are sequenced over 3-5 cycles per instruction. A wait
// counter in FETCH/MEMRD/MEMWR turns a stalled memory into a mem_fault pulse.
module multicycle_controller #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_read,
  output logic       mem_write,
  output logic       iord,
  output logic       ir_write,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_option,
  output logic       imm_zext,
  output logic [1:0] pc_src,
  output logic       pc_en,
  output logic       illegal_op,
  output logic       mem_fault,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    StFetch  = 4'd0,
    StDecode = 4'd1,
    StMemAdr = 4'd2,
    StMemRd  = 4'd3,
    StMemWb  = 4'd4,
    StMemWr  = 4'd5,
    StExec   = 4'd6,
    StAluWb  = 4'd7,
    StBranch = 4'd8,
    StIExec  = 4'd9,
    StIWb    = 4'd10,
    StJump   = 4'd11
  } state_t;

  localparam logic [5:0] OpR    = 6'b000000;
  localparam logic [5:0] OpLw   = 6'b100011;
  localparam logic [5:0] OpSw   = 6'b101011;
  localparam logic [5:0] OpBeq  = 6'b000100;
  localparam logic [5:0] OpAddi = 6'b001000;
  localparam logic [5:0] OpOri  = 6'b001101;
  localparam logic [5:0] OpJ    = 6'b000010;

  // Counter only needs to reach TIMEOUT_CYCLES-1; it saturates at all ones.
  localparam int unsigned CntW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

  state_t          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            waiting;
  logic            timeout;
  logic            pc_write;
  logic            branch;

  assign waiting = (state_q inside {StFetch, StMemRd, StMemWr}) && !mem_ready;
  assign timeout = (TIMEOUT_CYCLES != 0) && waiting && (cnt_q == CntLast);

  // Next-state and wait-counter update
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StFetch:  if (mem_ready) state_d = StDecode;
                else if (timeout) state_d = StFetch;
      StDecode: begin
        unique case (op)
          OpLw, OpSw:     state_d = StMemAdr;
          OpR:            state_d = StExec;
          OpBeq:          state_d = StBranch;
          OpAddi, OpOri:  state_d = StIExec;
          OpJ:            state_d = StJump;
          default:        state_d = StFetch;
        endcase
      end
      StMemAdr: state_d = (op == OpLw) ? StMemRd : StMemWr;
      StMemRd:  if (mem_ready) state_d = StMemWb;
                else if (timeout) state_d = StFetch;
      StMemWb:  state_d = StFetch;
      StMemWr:  if (mem_ready || timeout) state_d = StFetch;
      StExec:   state_d = StAluWb;
      StAluWb:  state_d = StFetch;
      StBranch: state_d = StFetch;
      StIExec:  state_d = StIWb;
      StIWb:    state_d = StFetch;
      StJump:   state_d = StFetch;
      default:  state_d = StFetch;
    endcase

    // Any state change (including timeout re-entry of FETCH) restarts the count.
    cnt_d = cnt_q;
    if (mem_ready || timeout || (state_d != state_q)) begin
      cnt_d = '0;
    end else if (waiting && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // State and wait-counter registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StFetch;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Moore decode of the current state; everything forced low during reset
  always_comb begin
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    iord       = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    alu_option = 2'b00;
    imm_zext   = 1'b0;
    pc_src     = 2'b00;
    pc_write   = 1'b0;
    branch     = 1'b0;
    illegal_op = 1'b0;
    mem_fault  = 1'b0;
    if (!reset) begin
      mem_fault = timeout;
      unique case (state_q)
        StFetch: begin
          mem_read  = !timeout;
          alu_src_b = 2'b01;
          ir_write  = mem_ready;
          pc_write  = mem_ready;
        end
        StDecode: begin
          alu_src_b = 2'b11;
          illegal_op = !(op inside {OpLw, OpSw, OpR, OpBeq, OpAddi, OpOri, OpJ});
        end
        StMemAdr: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
        end
        StMemRd: begin
          iord     = 1'b1;
          mem_read = !timeout;
        end
        StMemWb: begin
          mem_to_reg = 1'b1;
          reg_write  = 1'b1;
        end
        StMemWr: begin
          iord      = 1'b1;
          mem_write = !timeout;
        end
        StExec: begin
          alu_src_a  = 1'b1;
          alu_option = 2'b10;
        end
        StAluWb: begin
          reg_dst   = 1'b1;
          reg_write = 1'b1;
        end
        StBranch: begin
          alu_src_a  = 1'b1;
          alu_option = 2'b01;
          pc_src     = 2'b01;
          branch     = 1'b1;
        end
        StIExec: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
          if (op == OpOri) begin
            alu_option = 2'b11;
            imm_zext   = 1'b1;
          end
        end
        StIWb: reg_write = 1'b1;
        StJump: begin
          pc_src   = 2'b10;
          pc_write = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign pc_en = pc_write | (branch & zero);
  assign state = state_q;

endmodule
